// File: rtl/seg_pkg.sv
// Shared types and active-low segment encodings for the seven-segment scan driver.
package seg_pkg;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_MIN  = 2'd2
  } dig_e;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [2:0] AN_OFF = 3'b111;

  function automatic logic [2:0] dig_an(input dig_e d);
    case (d)
      DIG_ONES: dig_an = 3'b110;
      DIG_TENS: dig_an = 3'b101;
      DIG_MIN:  dig_an = 3'b011;
      default:  dig_an = AN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-decimal nibbles show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed common-anode driver with per-frame latch, dead time and minutes blanking.
// Optional blink support is compiled in with SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 2000,
  parameter int DEAD      = 4
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV = 64
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd,
  input  logic        blank,
`ifdef SEG_BLINK_EN
  input  logic        blink,
`endif
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] ctr;
  dig_e          idx;
  logic [11:0]   frm;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          slot_end, frm_ld, dead, min_blank, dark, lit;

  assign slot_end  = (ctr == CW'(SCAN_DIV - 1));
  assign frm_ld    = slot_end && (idx == DIG_MIN);
  assign dead      = (ctr < CW'(DEAD));
  assign min_blank = (idx == DIG_MIN) && (frm[11:8] == 4'd0);
  assign lit       = !dark && !dead && !min_blank;

  always_comb begin
    nib = frm[3:0];
    case (idx)
      DIG_ONES: nib = frm[3:0];
      DIG_TENS: nib = frm[7:4];
      DIG_MIN:  nib = frm[11:8];
      default:  nib = frm[3:0];
    endcase
  end

  bcd_to_seg u_dec (.nib(nib), .seg(dec));

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0] fcnt;
  logic          phase;

  // Dropping blink restarts the blink cadence so the next request begins lit.
  always_ff @(posedge clk) begin
    if (reset || !blink) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frm_ld) begin
      if (fcnt == FW'(BLINK_DIV - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign dark = blank || (blink && phase);
`else
  assign dark = blank;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr <= '0;
      idx <= DIG_ONES;
      frm <= '0;
    end else begin
      ctr <= slot_end ? '0 : ctr + 1'b1;
      if (slot_end) begin
        case (idx)
          DIG_ONES: idx <= DIG_TENS;
          DIG_TENS: idx <= DIG_MIN;
          default:  idx <= DIG_ONES;
        endcase
      end
      if (frm_ld) frm <= bcd;
    end
  end

  // Pins are registered from the pre-edge scan state, so they trail ctr/idx by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? dig_an(idx) : AN_OFF;
      seg <= (dark || min_blank) ? SEG_OFF : dec;
      dp  <= !(lit && (idx == DIG_MIN));
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a cycle-count arithmetic model.
module tb_seg_scan_driver;

  localparam int S  = 8;
  localparam int D  = 2;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] bcd = 12'h205;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;
`ifdef SEG_BLINK_EN
  logic        blink = 1'b0;
  int          fc = 0;
`endif

  int checks = 0;
  int fails  = 0;

  // Model state: cycles since reset release and the frame word latched so far.
  int          n = 0;
  logic [11:0] mfrm = '0;

  logic [6:0] dec_tbl [16];

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV(S),
    .DEAD(D)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_DIV(BD)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bcd(bcd),
    .blank(blank),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got=%0h want=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [11:0] b, input logic bk);
    int c, i, nb;
    logic dark, mb, chk_seg, chk_dp;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    @(negedge clk);
    reset = r; bcd = b; blank = bk;
    c  = n % S;
    i  = (n / S) % 3;
    nb = int'((mfrm >> (4 * i)) & 12'hF);
    dark = bk;
`ifdef SEG_BLINK_EN
    dark = dark || (blink && (((fc / BD) % 2) == 1));
`endif
    mb = (i == 2) && (mfrm[11:8] == 4'd0);
    chk_seg = 1'b1; chk_dp = 1'b1;
    e_seg = 7'h7F; e_dp = 1'b1;
    if (r) begin
      e_an = 3'b111;
    end else begin
      e_an = (dark || c < D || mb) ? 3'b111 : 3'(3'b111 & ~(3'b001 << i));
      if (!dark) begin
        e_seg = dec_tbl[nb];
        chk_seg = (e_an != 3'b111);
      end
      if (e_an != 3'b111) e_dp = (i == 2) ? 1'b0 : 1'b1;
      else chk_dp = dark || mb || (i != 2);
    end
    @(posedge clk);
    #1;
    chk("an", 16'(an), 16'(e_an));
    if (chk_seg) chk("seg", 16'(seg), 16'(e_seg));
    if (chk_dp)  chk("dp", 16'(dp), 16'(e_dp));
    if (r) begin
      n = 0; mfrm = '0;
`ifdef SEG_BLINK_EN
      fc = 0;
`endif
    end else begin
`ifdef SEG_BLINK_EN
      if (!blink) fc = 0;
      else if (c == S - 1 && i == 2) fc++;
`endif
      if (c == S - 1 && i == 2) mfrm = b;
      n++;
    end
  endtask

  function automatic logic [11:0] rnd_bcd();
    logic [11:0] v;
    v = 12'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      v[3:0]  = 4'($urandom_range(0, 9));
      v[7:4]  = 4'($urandom_range(0, 5));
      v[11:8] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    logic [11:0] rb;
    logic rbk;
    dec_tbl[0] = 7'b1000000; dec_tbl[1] = 7'b1111001; dec_tbl[2] = 7'b0100100;
    dec_tbl[3] = 7'b0110000; dec_tbl[4] = 7'b0011001; dec_tbl[5] = 7'b0010010;
    dec_tbl[6] = 7'b0000010; dec_tbl[7] = 7'b1111000; dec_tbl[8] = 7'b0000000;
    dec_tbl[9] = 7'b0010000;
    for (int k = 10; k < 16; k++) dec_tbl[k] = 7'b0111111;

    for (int k = 0; k < 3; k++) step(1'b1, 12'h205, 1'b0);
    for (int k = 0; k < 6 * S; k++) step(1'b0, 12'h205, 1'b0);
    // Frame-latch isolation: change bcd partway through the tens slot.
    for (int k = 0; k < 3 * S + S + 3; k++) step(1'b0, 12'h120, 1'b0);
    for (int k = 0; k < 6 * S; k++) step(1'b0, 12'h119, 1'b0);
    for (int k = 0; k < 6 * S; k++) step(1'b0, 12'h05F, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 12'h347, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 12'h347, 1'b1);
    for (int k = 0; k < 4 * S; k++) step(1'b0, 12'h347, 1'b0);

    rb = rnd_bcd(); rbk = 1'b0;
    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 15) == 0) rb = rnd_bcd();
      if ($urandom_range(0, 31) == 0) rbk = ~rbk;
      step(1'b0, rb, rbk);
    end
    // Mid-frame reset returns to a blank-minutes "00" first frame.
    step(1'b1, 12'h987, 1'b0);
    for (int k = 0; k < 6 * S; k++) step(1'b0, 12'h987, 1'b0);

`ifdef SEG_BLINK_EN
    blink = 1'b1;
    for (int k = 0; k < 15 * S + 4; k++) step(1'b0, 12'h456, 1'b0);
    blink = 1'b0;
    for (int k = 0; k < 4 * S; k++) step(1'b0, 12'h456, 1'b0);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 40) == 0) blink = ~blink;
      step(1'b0, 12'h178, 1'b0);
    end
    blink = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed three-digit seven-segment driver that consumes the timer's 12-bit BCD time word (minutes, tens-of-seconds, ones-of-seconds) and scans it onto a common-anode display. It sits directly downstream of the toaster timer. It latches the BCD word once per frame so a digit never changes mid-frame, inserts anode dead time against ghosting, and blanks a leading-zero minutes digit.

## Interface
Parameters:
- SCAN_DIV, 2000: clock cycles per digit slot; must be ≥ 2 and > DEAD.
- DEAD, 4: cycles at the start of each slot with all anodes off.
- BLINK_DIV, 64: frames per blink half-period; present only with SEG_BLINK_EN.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- bcd, input, 12: {minutes[11:8], tens[7:4], ones[3:0]} from the timer.
- blank, input, 1: forces the display dark; counters keep running.
- blink, input, 1: blink request; port exists only with SEG_BLINK_EN.
- seg, output, 7: active-low segments {g,f,e,d,c,b,a}.
- dp, output, 1: active-low colon/decimal point after the minutes digit.
- an, output, 3: active-low one-hot anodes; bit0 = ones, bit1 = tens, bit2 = minutes.

## Operation
- Prescaler ctr runs 0..SCAN_DIV-1 and wraps. At wrap, digit index idx advances 0→1→2→0 (ones, tens, minutes).
- Frame register frm loads bcd on the cycle where ctr = SCAN_DIV-1 and idx = 2. frm is therefore stable for a whole frame. A bcd change mid-frame appears only in the next frame.
- Per slot, the selected nibble is decoded as follows:
  - 0..9 use the encodings 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10..15 show a dash, 0111111.
- Leading-zero blank: if the minutes nibble = 0, the minutes slot drives an = 111 and dp = 1. In that case only the seconds are shown.
- dp = 0 only during a displayed minutes slot; otherwise dp = 1.
- Anode drive: when ctr < DEAD, an = 111. Otherwise an = ~(1<<idx), subject to blanking.
- When blank = 1, an = 111 and seg = 1111111.
- Reset values:
  - ctr = 0, idx = 0, frm = 0.
  - an = 111, seg = 1111111, dp = 1.
  - Blink counter and phase = 0.
- Reset mid-frame: the block returns to the reset state on the next edge. The first frame after reset displays frm = 0, i.e. "00" with the minutes slot blank. The new bcd is taken at the end of that first frame.

## Timing
- seg, dp and an are registered. Each is a function of the pre-edge ctr, idx, frm and blank, so pins lag the internal state by one cycle.
- Frame length = 3·SCAN_DIV cycles. Each digit is lit for SCAN_DIV−DEAD cycles per frame.
- Latency from a bcd change to the display: at most 3·SCAN_DIV + 1 cycles.
- blank asserted reaches the pins on the next edge. Deasserting it resumes mid-slot with no reset of the scan.
- Simultaneous frame latch and idx wrap on the same edge are intended: the new frm is used from slot idx = 0 onward.

## Configuration
- SEG_BLINK_EN defined:
  - The blink port and BLINK_DIV exist.
  - A frame counter toggles phase every BLINK_DIV completed frames.
  - While blink = 1 and phase = 1, the display is dark, as if blank were set.
  - When blink goes to 0, phase clears to 0 on the next edge.
- SEG_BLINK_EN undefined: no blink port, no frame counter, no phase register. Behaviour is otherwise identical.

## Structure
- Package seg_pkg contains:
  - The digit index typedef (2-bit enum DIG_ONES, DIG_TENS, DIG_MIN).
  - The SEG_* active-low encoding constants, including SEG_DASH and SEG_OFF.
- Sub-module bcd_to_seg: combinational 4-bit to 7-bit decoder, instantiated once on the selected nibble.

## Test plan
Bench uses SCAN_DIV = 8, DEAD = 2, BLINK_DIV = 2.
- Reset held 3 cycles, then released with bcd = 0x205:
  - First frame: an = 111 for the minutes slot.
  - Second frame: ones slot shows seg = 0010010 with an = 110; tens shows 1000000 with an = 101; minutes shows 0100100 with an = 011 and dp = 0.
- Dead time: in every slot, an = 111 for exactly 2 cycles, then low for 6 cycles.
- bcd changes from 0x120 to 0x119 mid-frame (during the tens slot): the tens digit keeps showing 2 until the next frame, then shows 1.
- bcd = 0x05F: the ones slot shows 0111111 (dash); the minutes slot stays dark with dp = 1.
- blank pulsed for 5 cycles: an = 111 and seg = 1111111 from the next edge. On release, scanning resumes at the ctr/idx position it would otherwise have reached.
- SEG_BLINK_EN with blink = 1: the display alternates 2 frames lit and 2 frames dark. Dropping blink restores a lit display within 1 cycle of the next slot start.
